// File: rtl/muntjac_metadata_ctrl.sv
// Sequencer/arbiter in front of muntjac_metadata_table: owns the per-entry state
// storage, round-robins four event sources and performs read-lookup-writeback.
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | sweep writes INIT_STATE to every entry, no accepts
// RUN   | arbitrate into S1, look up and write back S1 every cycle
// HALT  | table raised an exception; S1 held until exc_clear_i
module muntjac_metadata_ctrl #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES),
    parameter logic [7:0]  INIT_STATE  = 8'd0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [3:0]           req_valid_i,
    input  logic [4*IDX_W-1:0]   req_idx_i,
    output logic [3:0]           req_ready_o,
    output logic                 tbl_valid_o,
    output logic [7:0]           tbl_state_o,
    output logic [3:0]           tbl_event_o,
    input  logic [7:0]           tbl_state_i,
    input  logic                 tbl_exception_i,
    output logic                 resp_valid_o,
    output logic [1:0]           resp_src_o,
    output logic [IDX_W-1:0]     resp_idx_o,
    output logic [7:0]           resp_state_o,
    output logic                 resp_exception_o,
    input  logic                 flush_i,
    input  logic                 exc_clear_i,
    output logic                 busy_o,
    output logic                 halted_o
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [1:0]       r_rr;
    logic             r_s1_valid;
    logic [1:0]       r_s1_src;
    logic [IDX_W-1:0] r_s1_idx;
    logic [7:0]       r_mem [NUM_ENTRIES];

    logic             r_resp_valid;
    logic [1:0]       r_resp_src;
    logic [IDX_W-1:0] r_resp_idx;
    logic [7:0]       r_resp_state;
    logic             r_resp_exc;

    logic             w_grant_any;
    logic [1:0]       w_grant_src;
    logic [1:0]       w_cand;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_accept;
    logic             w_lookup;

    // First valid source at or after the round-robin pointer wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_src = r_rr;
        w_cand      = r_rr;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_rr + 2'(k);
            if (!w_grant_any && req_valid_i[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_src = w_cand;
            end
        end
    end

    assign w_grant_idx = req_idx_i[w_grant_src*IDX_W +: IDX_W];
    assign w_accept    = (r_state == ST_RUN) && !flush_i && w_grant_any;
    assign w_lookup    = (r_state == ST_RUN) && !flush_i && r_s1_valid;

    assign req_ready_o = w_accept ? (4'b0001 << w_grant_src) : 4'b0000;
    assign tbl_valid_o = w_lookup;
    assign tbl_state_o = w_lookup ? r_mem[r_s1_idx] : 8'd0;
    assign tbl_event_o = w_lookup ? {2'b00, r_s1_src} : 4'd0;

    assign resp_valid_o     = r_resp_valid;
    assign resp_src_o       = r_resp_src;
    assign resp_idx_o       = r_resp_idx;
    assign resp_state_o     = r_resp_state;
    assign resp_exception_o = r_resp_exc;
    assign busy_o           = (r_state == ST_INIT);
    assign halted_o         = (r_state == ST_HALT);

    // Storage has no reset of its own; the INIT sweep initialises it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            if (r_state == ST_INIT) begin
                r_mem[r_ptr] <= INIT_STATE;
            end else if (w_lookup) begin
                r_mem[r_s1_idx] <= tbl_state_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_INIT;
            r_ptr        <= '0;
            r_rr         <= 2'd0;
            r_s1_valid   <= 1'b0;
            r_s1_src     <= 2'd0;
            r_s1_idx     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_src   <= 2'd0;
            r_resp_idx   <= '0;
            r_resp_state <= 8'd0;
            r_resp_exc   <= 1'b0;
        end else begin
            r_resp_valid <= w_lookup;
            if (w_lookup) begin
                r_resp_src   <= r_s1_src;
                r_resp_idx   <= r_s1_idx;
                r_resp_state <= tbl_state_i;
                r_resp_exc   <= tbl_exception_i;
            end
            if (flush_i) begin
                r_state    <= ST_INIT;
                r_ptr      <= '0;
                r_s1_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        r_ptr <= r_ptr + IDX_W'(1);
                        if (r_ptr == IDX_W'(NUM_ENTRIES - 1)) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        r_s1_valid <= w_accept;
                        if (w_accept) begin
                            r_s1_src <= w_grant_src;
                            r_s1_idx <= w_grant_idx;
                            r_rr     <= w_grant_src + 2'd1;
                        end
                        if (w_lookup && tbl_exception_i) begin
                            r_state <= ST_HALT;
                        end
                    end
                    ST_HALT: begin
                        if (exc_clear_i) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muntjac_metadata_ctrl.sv
// Directed bench for muntjac_metadata_ctrl with a small combinational table model:
// load keeps state, store +4, uevt0 +1, uevt1 +2; exception forced on store when armed.
module tb_muntjac_metadata_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  req_valid_i;
    logic [15:0] req_idx_i;
    logic [3:0]  req_ready_o;
    logic        tbl_valid_o;
    logic [7:0]  tbl_state_o;
    logic [3:0]  tbl_event_o;
    logic [7:0]  tbl_state_i;
    logic        tbl_exception_i;
    logic        resp_valid_o;
    logic [1:0]  resp_src_o;
    logic [3:0]  resp_idx_o;
    logic [7:0]  resp_state_o;
    logic        resp_exception_o;
    logic        flush_i;
    logic        exc_clear_i;
    logic        busy_o;
    logic        halted_o;
    logic        exc_arm;

    int n_tests = 0;
    int n_fail  = 0;

    muntjac_metadata_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_idx_i(req_idx_i), .req_ready_o(req_ready_o),
        .tbl_valid_o(tbl_valid_o), .tbl_state_o(tbl_state_o), .tbl_event_o(tbl_event_o),
        .tbl_state_i(tbl_state_i), .tbl_exception_i(tbl_exception_i),
        .resp_valid_o(resp_valid_o), .resp_src_o(resp_src_o), .resp_idx_o(resp_idx_o),
        .resp_state_o(resp_state_o), .resp_exception_o(resp_exception_o),
        .flush_i(flush_i), .exc_clear_i(exc_clear_i),
        .busy_o(busy_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        case (tbl_event_o[1:0])
            2'd0:    tbl_state_i = tbl_state_o;
            2'd1:    tbl_state_i = tbl_state_o + 8'd4;
            2'd2:    tbl_state_i = tbl_state_o + 8'd1;
            default: tbl_state_i = tbl_state_o + 8'd2;
        endcase
        tbl_exception_i = exc_arm && tbl_valid_o && (tbl_event_o == 4'd1);
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst_ni = 1'b0; req_valid_i = 4'hF; req_idx_i = '0;
        flush_i = 1'b0; exc_clear_i = 1'b0; exc_arm = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        n_tests++;
        if ({busy_o, halted_o, req_ready_o, tbl_valid_o, resp_valid_o, tbl_state_o, tbl_event_o} !==
            {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b halted=%0b ready=%h tv=%0b rv=%0b ts=%h te=%h, expected busy=1 rest 0",
                     busy_o, halted_o, req_ready_o, tbl_valid_o, resp_valid_o, tbl_state_o, tbl_event_o);
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            n_tests++;
            if ({busy_o, req_ready_o} !== {1'b1, 4'h0}) begin
                n_fail++;
                $display("FAIL init_busy cycle %0d: busy=%0b ready=%h, expected busy=1 ready=0", c, busy_o, req_ready_o);
            end
        end
        @(negedge clk_i); #1;
        n_tests++;
        if ({busy_o, halted_o, req_ready_o} !== {1'b0, 1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL run_at_16: busy=%0b halted=%0b ready=%h, expected 0 0 1", busy_o, halted_o, req_ready_o);
        end
        req_valid_i = 4'h0;
    endtask

    task automatic test_init_contents();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            req_valid_i = 4'b0001; req_idx_i = '0; req_idx_i[3:0] = 4'(i); #1;
            n_tests++;
            if (req_ready_o !== 4'b0001) begin
                n_fail++;
                $display("FAIL init_rd_grant idx %0d: ready=%h expected 1", i, req_ready_o);
            end
            @(negedge clk_i); req_valid_i = 4'h0; #1;
            n_tests++;
            if ({tbl_valid_o, tbl_state_o} !== {1'b1, 8'h00}) begin
                n_fail++;
                $display("FAIL init_rd_state idx %0d: tv=%0b state=%h expected 1 00", i, tbl_valid_o, tbl_state_o);
            end
            @(negedge clk_i); #1;
        end
    endtask

    task automatic test_single();
        @(negedge clk_i);
        req_valid_i = 4'b0100; req_idx_i = '0; req_idx_i[11:8] = 4'd5; #1;
        n_tests++;
        if (req_ready_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: ready=%h expected 4", req_ready_o);
        end
        @(negedge clk_i); req_valid_i = 4'h0; #1;
        n_tests++;
        if ({tbl_valid_o, tbl_state_o, tbl_event_o, resp_valid_o} !== {1'b1, 8'h00, 4'h2, 1'b0}) begin
            n_fail++;
            $display("FAIL single_lookup: tv=%0b ts=%h te=%h rv=%0b expected 1 00 2 0",
                     tbl_valid_o, tbl_state_o, tbl_event_o, resp_valid_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if ({resp_valid_o, resp_state_o, resp_exception_o, resp_src_o, resp_idx_o} !==
            {1'b1, 8'h01, 1'b0, 2'd2, 4'd5}) begin
            n_fail++;
            $display("FAIL single_resp: rv=%0b st=%h exc=%0b src=%0d idx=%0d expected 1 01 0 2 5",
                     resp_valid_o, resp_state_o, resp_exception_o, resp_src_o, resp_idx_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: rv=%0b expected 0", resp_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        req_valid_i = 4'b0100; req_idx_i = '0; req_idx_i[11:8] = 4'd12;
        @(negedge clk_i);
        req_valid_i = 4'h0; rst_ni = 1'b0;
        @(negedge clk_i); #1;
        n_tests++;
        if ({resp_valid_o, busy_o, tbl_valid_o} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: rv=%0b busy=%0b tv=%0b expected 0 1 0", resp_valid_o, busy_o, tbl_valid_o);
        end
        rst_ni = 1'b1;
        repeat (15) @(negedge clk_i);
        #1;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy15: busy=%0b expected 1", busy_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%0b expected 0", busy_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy [5];
        logic [1:0] exp_src [5];
        logic [7:0] exp_st  [5];
        logic [3:0] exp_pr  [3];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_st  = '{8'd0, 8'd4, 8'd1, 8'd2, 8'd0};
        exp_pr  = '{4'b0010, 4'b1000, 4'b0010};
        req_idx_i = {4'd6, 4'd4, 4'd2, 4'd1};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            req_valid_i = (c < 5) ? 4'hF : 4'h0; #1;
            if (c < 5) begin
                n_tests++;
                if (req_ready_o !== exp_rdy[c]) begin
                    n_fail++;
                    $display("FAIL rr_grant cycle %0d: ready=%h expected %h", c, req_ready_o, exp_rdy[c]);
                end
            end
            if (c >= 2 && c < 7) begin
                n_tests++;
                if ({resp_valid_o, resp_src_o, resp_state_o} !== {1'b1, exp_src[c-2], exp_st[c-2]}) begin
                    n_fail++;
                    $display("FAIL rr_resp cycle %0d: rv=%0b src=%0d st=%h expected 1 %0d %h",
                             c, resp_valid_o, resp_src_o, resp_state_o, exp_src[c-2], exp_st[c-2]);
                end
            end
            if (c == 7) begin
                n_tests++;
                if (resp_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_drain: rv=%0b expected 0", resp_valid_o);
                end
            end
        end
        req_idx_i = {4'd9, 4'd0, 4'd8, 4'd0};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            req_valid_i = 4'b1010; #1;
            n_tests++;
            if (req_ready_o !== exp_pr[c]) begin
                n_fail++;
                $display("FAIL rr_partial cycle %0d: ready=%h expected %h", c, req_ready_o, exp_pr[c]);
            end
        end
        @(negedge clk_i); req_valid_i = 4'h0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        req_valid_i = 4'b0100; req_idx_i = '0; req_idx_i[11:8] = 4'd3; #1;
        n_tests++;
        if (req_ready_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL b2b_grant0: ready=%h expected 4", req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = 4'b0001; req_idx_i = '0; req_idx_i[3:0] = 4'd3; #1;
        n_tests++;
        if ({req_ready_o, tbl_state_o, tbl_event_o} !== {4'b0001, 8'h00, 4'h2}) begin
            n_fail++;
            $display("FAIL b2b_first: ready=%h ts=%h te=%h expected 1 00 2", req_ready_o, tbl_state_o, tbl_event_o);
        end
        @(negedge clk_i); req_valid_i = 4'h0; #1;
        n_tests++;
        if ({tbl_valid_o, tbl_state_o, tbl_event_o} !== {1'b1, 8'h01, 4'h0}) begin
            n_fail++;
            $display("FAIL b2b_second_lookup: tv=%0b ts=%h te=%h expected 1 01 0", tbl_valid_o, tbl_state_o, tbl_event_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if ({resp_valid_o, resp_src_o, resp_idx_o, resp_state_o} !== {1'b1, 2'd0, 4'd3, 8'h01}) begin
            n_fail++;
            $display("FAIL b2b_final: rv=%0b src=%0d idx=%0d st=%h expected 1 0 3 01",
                     resp_valid_o, resp_src_o, resp_idx_o, resp_state_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_exception();
        exc_arm = 1'b1;
        @(negedge clk_i);
        req_valid_i = 4'b0010; req_idx_i = '0; req_idx_i[7:4] = 4'd7;
        @(negedge clk_i);
        req_valid_i = 4'b0001; req_idx_i = '0; req_idx_i[3:0] = 4'd2; #1;
        n_tests++;
        if ({req_ready_o, tbl_valid_o, tbl_event_o} !== {4'b0001, 1'b1, 4'h1}) begin
            n_fail++;
            $display("FAIL exc_lookup: ready=%h tv=%0b te=%h expected 1 1 1", req_ready_o, tbl_valid_o, tbl_event_o);
        end
        @(negedge clk_i);
        req_valid_i = 4'hF; exc_arm = 1'b0; #1;
        n_tests++;
        if ({halted_o, req_ready_o, tbl_valid_o, resp_valid_o, resp_exception_o, resp_src_o, resp_idx_o, resp_state_o} !==
            {1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd7, 8'h04}) begin
            n_fail++;
            $display("FAIL exc_halt: hlt=%0b rdy=%h tv=%0b rv=%0b exc=%0b src=%0d idx=%0d st=%h expected 1 0 0 1 1 1 7 04",
                     halted_o, req_ready_o, tbl_valid_o, resp_valid_o, resp_exception_o, resp_src_o, resp_idx_o, resp_state_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if ({halted_o, req_ready_o, resp_valid_o} !== {1'b1, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL exc_hold: hlt=%0b rdy=%h rv=%0b expected 1 0 0", halted_o, req_ready_o, resp_valid_o);
        end
        @(negedge clk_i);
        req_valid_i = 4'h0; exc_clear_i = 1'b1;
        @(negedge clk_i);
        exc_clear_i = 1'b0; #1;
        n_tests++;
        if ({halted_o, tbl_valid_o, tbl_event_o, tbl_state_o, resp_valid_o} !== {1'b0, 1'b1, 4'h0, 8'h04, 1'b0}) begin
            n_fail++;
            $display("FAIL exc_clear_lookup: hlt=%0b tv=%0b te=%h ts=%h rv=%0b expected 0 1 0 04 0",
                     halted_o, tbl_valid_o, tbl_event_o, tbl_state_o, resp_valid_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if ({resp_valid_o, resp_src_o, resp_idx_o, resp_state_o, resp_exception_o} !== {1'b1, 2'd0, 4'd2, 8'h04, 1'b0}) begin
            n_fail++;
            $display("FAIL exc_held_resp: rv=%0b src=%0d idx=%0d st=%h exc=%0b expected 1 0 2 04 0",
                     resp_valid_o, resp_src_o, resp_idx_o, resp_state_o, resp_exception_o);
        end
        @(negedge clk_i);
        req_valid_i = 4'b0001; req_idx_i = '0; req_idx_i[3:0] = 4'd7;
        @(negedge clk_i); req_valid_i = 4'h0; #1;
        n_tests++;
        if ({tbl_valid_o, tbl_state_o} !== {1'b1, 8'h04}) begin
            n_fail++;
            $display("FAIL exc_writeback: tv=%0b ts=%h expected 1 04", tbl_valid_o, tbl_state_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_flush();
        exc_arm = 1'b1;
        @(negedge clk_i);
        req_valid_i = 4'b0010; req_idx_i = '0; req_idx_i[7:4] = 4'd10;
        @(negedge clk_i);
        req_valid_i = 4'b0001; req_idx_i = '0; req_idx_i[3:0] = 4'd11;
        @(negedge clk_i);
        req_valid_i = 4'h0; exc_arm = 1'b0; flush_i = 1'b1; exc_clear_i = 1'b1; #1;
        n_tests++;
        if ({halted_o, req_ready_o, resp_valid_o, resp_exception_o} !== {1'b1, 4'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_halt_resp: hlt=%0b rdy=%h rv=%0b exc=%0b expected 1 0 1 1",
                     halted_o, req_ready_o, resp_valid_o, resp_exception_o);
        end
        @(negedge clk_i);
        flush_i = 1'b0; exc_clear_i = 1'b0; #1;
        n_tests++;
        if ({busy_o, halted_o, resp_valid_o} !== {1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_to_init: busy=%0b hlt=%0b rv=%0b expected 1 0 0", busy_o, halted_o, resp_valid_o);
        end
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk_i); #1;
            n_tests++;
            if ({busy_o, resp_valid_o, tbl_valid_o} !== {1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL flush_dropped cycle %0d: busy=%0b rv=%0b tv=%0b expected 1 0 0",
                         j, busy_o, resp_valid_o, tbl_valid_o);
            end
        end
        flush_i = 1'b1; req_valid_i = 4'hF; #1;
        n_tests++;
        if (req_ready_o !== 4'h0) begin
            n_fail++;
            $display("FAIL flush_mid_init_ready: ready=%h expected 0", req_ready_o);
        end
        @(negedge clk_i);
        flush_i = 1'b0; req_valid_i = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            n_tests++;
            if (busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_restart_busy cycle %0d: busy=%0b expected 1", i, busy_o);
            end
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_restart_run: busy=%0b expected 0", busy_o);
        end
        req_valid_i = 4'b0001; req_idx_i = '0; req_idx_i[3:0] = 4'd7;
        @(negedge clk_i); req_valid_i = 4'h0; #1;
        n_tests++;
        if ({tbl_valid_o, tbl_state_o} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL flush_swept: tv=%0b ts=%h expected 1 00", tbl_valid_o, tbl_state_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_init_contents();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_back_to_back();
        test_exception();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
